// File: rtl/add_prefix_pipe.sv
// Pipelined Kogge-Stone prefix adder/subtractor with a valid/ready handshake.
// S0 registers the bit-level generate/propagate terms, and S1..SL each register one prefix level.
module add_prefix_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);

    logic [L:0]       v_q;
    logic [WIDTH-1:0] g_q   [0:L];
    logic [WIDTH-1:0] pg_q  [0:L];
    logic [WIDTH-1:0] p_q   [0:L];
    logic             cin_q [0:L];
    logic             amsb_q[0:L];
    logic             bmsb_q[0:L];
    logic [TAG_W-1:0] tag_q [0:L];

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] s0_p;
    logic [WIDTH-1:0] s0_g;
    logic [WIDTH-1:0] lvl_g_d [1:L];
    logic [WIDTH-1:0] lvl_pg_d[1:L];
    logic [L:0]       load;

    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;
    assign s0_p    = in_a ^ b_eff;
    // The carry-in is folded into bit 0, so its generate is already the final carry out of bit 0.
    assign s0_g    = (in_a & b_eff) | {{(WIDTH-1){1'b0}}, s0_p[0] & cin_eff};

    always_comb begin
        for (int j = 1; j <= L; j++) begin
            lvl_g_d[j]  = g_q[j-1];
            lvl_pg_d[j] = pg_q[j-1];
            for (int i = (1 << (j-1)); i < WIDTH; i++) begin
                lvl_g_d[j][i]  = g_q[j-1][i] | (pg_q[j-1][i] & g_q[j-1][i-(1 << (j-1))]);
                lvl_pg_d[j][i] = pg_q[j-1][i] & pg_q[j-1][i-(1 << (j-1))];
            end
        end
    end

    // Stage j can load unless it and every stage after it hold data while the output is stalled.
    always_comb begin
        load = '0;
        for (int j = 0; j <= L; j++) begin
            load[j] = out_ready | ~(&(v_q | (L+1)'((1 << j) - 1)));
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            for (int j = 0; j <= L; j++) begin
                g_q[j]    <= '0;
                pg_q[j]   <= '0;
                p_q[j]    <= '0;
                cin_q[j]  <= 1'b0;
                amsb_q[j] <= 1'b0;
                bmsb_q[j] <= 1'b0;
                tag_q[j]  <= '0;
            end
        end else begin
            if (load[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    g_q[0]    <= s0_g;
                    pg_q[0]   <= s0_p;
                    p_q[0]    <= s0_p;
                    cin_q[0]  <= cin_eff;
                    amsb_q[0] <= in_a[WIDTH-1];
                    bmsb_q[0] <= b_eff[WIDTH-1];
                    tag_q[0]  <= in_tag;
                end
            end
            for (int j = 1; j <= L; j++) begin
                if (load[j]) begin
                    v_q[j] <= v_q[j-1];
                    if (v_q[j-1]) begin
                        g_q[j]    <= lvl_g_d[j];
                        pg_q[j]   <= lvl_pg_d[j];
                        p_q[j]    <= p_q[j-1];
                        cin_q[j]  <= cin_q[j-1];
                        amsb_q[j] <= amsb_q[j-1];
                        bmsb_q[j] <= bmsb_q[j-1];
                        tag_q[j]  <= tag_q[j-1];
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] carries;
    logic [WIDTH-1:0] sum_raw;

    assign carries = {g_q[L][WIDTH-2:0], cin_q[L]};
    assign sum_raw = p_q[L] ^ carries;

    // The outputs are gated by valid, so an empty stage reports all zeros (including out_zero).
    assign out_valid = v_q[L];
    assign out_sum   = v_q[L] ? sum_raw : '0;
    assign out_cout  = v_q[L] & g_q[L][WIDTH-1];
    assign out_ovf   = v_q[L] & (amsb_q[L] == bmsb_q[L]) & (sum_raw[WIDTH-1] != amsb_q[L]);
    assign out_zero  = v_q[L] & (sum_raw == '0);
    assign out_tag   = v_q[L] ? tag_q[L] : '0;

endmodule

// File: tb/tb_add_prefix_pipe.sv
// Scoreboard bench for add_prefix_pipe: an arithmetic reference model fills a queue, and a monitor drains it.
module tb_add_prefix_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int L  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    add_prefix_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
        int            cyc;
        bit            timed;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [TW-1:0] tag_ctr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic [TW-1:0] tag);
        exp_t         m;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
        m.sum  = full[W-1:0];
        m.cout = full[W];
        m.ovf  = (a[W-1] == bb[W-1]) && (m.sum[W-1] != a[W-1]);
        m.zero = (m.sum == '0);
        m.tag  = tag;
        m.cyc  = 0;
        m.timed = 1'b0;
        return m;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] corners [4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic do_cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic rdy,
                            input bit timed, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_tag    = tag_ctr;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e       = model(a, b, cin, sub, tag_ctr);
            e.cyc   = cyc + 1;
            e.timed = timed;
            sb.push_back(e);
            tag_ctr = tag_ctr + 1'b1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input bit timed);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) do_cycle(1'b1, a, b, cin, sub, 1'b1, timed, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready got 0 want 1");
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending got %0d want 0", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares each output transfer against the scoreboard head and checks that outputs hold during a stall.
    bit                      hold_p = 1'b0;
    logic [1+W+3+TW-1:0]     held;
    exp_t                    mh;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                checks++;
                if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== held) begin
                    errors++;
                    $display("FAIL hold_stable got %h want %h",
                             {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got sum=%h tag=%h want none", out_sum, out_tag);
                end else begin
                    mh = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !== {mh.sum, mh.cout, mh.ovf, mh.zero, mh.tag}) begin
                        errors++;
                        $display("FAIL result got sum=%h c=%b v=%b z=%b tag=%h want sum=%h c=%b v=%b z=%b tag=%h",
                                 out_sum, out_cout, out_ovf, out_zero, out_tag,
                                 mh.sum, mh.cout, mh.ovf, mh.zero, mh.tag);
                    end
                    if (mh.timed) begin
                        checks++;
                        if (cyc - mh.cyc != L) begin
                            errors++;
                            $display("FAIL latency got %0d want %0d", cyc - mh.cyc, L);
                        end
                    end
                end
            end
            hold_p = out_valid && !out_ready;
            held   = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int acc_cnt;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        tag_ctr   = 4'd3;

        #12;
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end

        // Directed corner cases, timed for exact latency
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        drain();

        // Streaming with back-to-back operations
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b1, rnd_operand(), rnd_operand(), 1'($urandom), 1'($urandom), 1'b1, 1'b1, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL stream_in_ready op %0d got 0 want 1", k);
            end
        end
        drain();

        // Backpressure: the output is stalled for 10 cycles while the driver keeps offering operations
        acc_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, rnd_operand(), rnd_operand(), 1'($urandom), 1'($urandom), 1'b0, 1'b0, acc);
            if (acc) acc_cnt++;
        end
        checks++;
        if (acc_cnt != L + 1) begin
            errors++;
            $display("FAIL stall_accepts got %0d want %0d", acc_cnt, L + 1);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got %b want 0", in_ready);
        end
        drain();

        // Random valid and ready patterns, so bubbles form and collapse
        for (int k = 0; k < 300; k++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), rnd_operand(), rnd_operand(), 1'($urandom),
                     1'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0, acc);
        end
        drain();

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++)
            do_cycle(1'b1, rnd_operand(), rnd_operand(), 1'($urandom), 1'($urandom), 1'b1, 1'b1, acc);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag});
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset cycle %0d got 1 want 0", k);
            end
        end
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
